tlc_phase_arbiter: RTL and testbench
====================================

# tlc_phase_arbiter

Four-approach intersection phase scheduler. It is the next step up from the two-road farm/highway controller. It shares the single "green" resource of an intersection among four approach sensors using round-robin arbitration. Each change of green is sequenced through yellow and all-red clearance intervals. The block contains its own clearance/green timer and sensor synchronizers, and drives the per-approach lamp codes directly.

## Interface
- `T_ALLRED`, default 50000000: all-red clearance duration in cycles (1 s at 50 MHz).
- `T_YELLOW`, default 150000000: yellow duration in cycles.
- `T_MIN_GREEN`, default 750000000: minimum green before a competing request may preempt.
- `T_MAX_GREEN`, default 1500000000: maximum green while a competing request is pending.
- Constraint: all parameters are ≥1 and < 2^31, with T_MIN_GREEN ≤ T_MAX_GREEN.
- `Clk`, input, 1: system clock. All state changes on the rising edge.
- `Rst`, input, 1: asynchronous, active-low reset.
- `req`, input, 4: raw approach sensors, one bit per approach, asynchronous to `Clk`.
- `signal`, output, 8: lamp code for approach i on `signal[2i+1:2i]`. Codes are green=2'b11, yellow=2'b10, red=2'b01.
- `grant`, output, 2: index of the approach currently owning the phase.
- `state`, output, 2: debug encoding. ALLRED=2'b00, GREEN=2'b01, YELLOW=2'b10.
- `pending`, output, 4: latched request bits (debug).

## Operation
- Each `req` bit passes through a 2-flop synchronizer. The result is `req_s`.
- Pending latch behaviour:
  - `pending[i]` sets on any cycle `req_s[i]`=1.
  - It is forced to 0 on every cycle approach i is in GREEN.
  - Set and force-clear in the same cycle resolves to clear.
- Timer `count` is 31 bits, unsigned. It clears to 0 on every state transition and otherwise increments by 1. In GREEN it saturates at T_MAX_GREEN-1.
- `other` = OR of `pending` bits excluding `grant`.
- ALLRED: every approach shows red. When `count` = T_ALLRED-1, the block goes to GREEN, loads `grant` ← `next_grant`, and clears `count`.
- GREEN: approach `grant` shows green and all others show red. The block goes to YELLOW when either condition holds:
  - (a) `other`=1 and `count` ≥ T_MIN_GREEN-1 and `req_s[grant]`=0 (demand gap), or
  - (b) `other`=1 and `count` ≥ T_MAX_GREEN-1 (max-out).
  - With `other`=0, the block remains in GREEN indefinitely (rest-in-green).
- GREEN→YELLOW latches `next_grant`. This is the first approach with `pending` set, searched in order `grant`+1, +2, +3 (mod 4). The decision uses `pending` as sampled on the transition cycle.
- YELLOW: approach `grant` shows yellow and all others show red. When `count` = T_YELLOW-1, the block goes to ALLRED.
- `grant` changes only on ALLRED→GREEN. During YELLOW/ALLRED it still names the outgoing approach.
- Reset (Rst=0, asynchronous) sets:
  - state=ALLRED, count=0, grant=0, next_grant=0;
  - pending=0, synchronizer flops=0;
  - signal=8'b01010101 (all red).
- Reset asserted mid-phase aborts immediately to the reset values. The lamps go all-red in the same instant, with no yellow.
- After reset release, the first GREEN goes to approach 0 (home approach) after T_ALLRED cycles, regardless of `req`.

## Timing
- Request latency: `req` rising → `pending` set on the 3rd rising edge (2 sync + 1 latch).
- Phase durations are exact:
  - YELLOW lasts T_YELLOW cycles.
  - ALLRED lasts T_ALLRED cycles.
  - Green lasts at least T_MIN_GREEN cycles when preempted by (a), and exactly T_MAX_GREEN cycles when preempted by (b) with a continuous competing request.
- `signal`, `grant` and `state` are decoded from registers only, with no combinational path from `req`. They change on the same edge as `state`.
- Round-robin fairness: with all four requests held, grants cycle 0→1→2→3→0. Each green lasts T_MAX_GREEN.
- `count` never wraps. Its maximum value is max(T_MAX_GREEN, T_YELLOW, T_ALLRED)-1.

## Test plan
Bench parameters for all scenarios: T_ALLRED=2, T_YELLOW=3, T_MIN_GREEN=5, T_MAX_GREEN=10.

1. Reset, no requests → signal=8'h55 for 2 cycles after release, then `signal[1:0]`=11 with `grant`=0. The block holds green indefinitely, with `state`=01 and `count` saturated at 9.
2. Green on 0, pulse `req[2]` for 1 cycle, `req[0]`=0 → `pending[2]` set 3 edges later. Yellow on 0 starts at green count 4 (5 green cycles), lasts 3 cycles, then 2 all-red cycles. Then `grant`=2, `signal[5:4]`=11 and `pending[2]`=0.
3. Green on 0 with `req[0]` held and `req[1]` held → no exit at count 4. Yellow begins after exactly 10 green cycles (max-out), and `grant`=1 follows.
4. All `req`=4'hF held → grant sequence 0,1,2,3,0. Each green lasts 10 cycles, and each yellow/all-red lasts 3/2 cycles.
5. `req[3]` and `req[1]` pending while `grant`=0 → next_grant=1 (round-robin order). After that phase, `grant`=3.
6. Assert Rst=0 mid-YELLOW (asynchronously, between edges) → signal=8'h55, state=00, grant=0 and pending=0 immediately. Normal sequence resumes after release, as in scenario 1.

Source files
------------

// File: rtl/tlc_phase_arbiter.sv
// Four-approach intersection phase scheduler.
// Round-robin hand-off of a single green phase among four approach sensors,
// sequenced through yellow and all-red clearance, with built-in sensor
// synchronizers, pending latches and a shared phase timer.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ALLRED  | every approach red; clearance before the next green
// GREEN   | approach `grant` green; rests here while nobody else waits
// YELLOW  | approach `grant` yellow; all others red
module tlc_phase_arbiter #(
  parameter int unsigned T_ALLRED    = 50000000,
  parameter int unsigned T_YELLOW    = 150000000,
  parameter int unsigned T_MIN_GREEN = 750000000,
  parameter int unsigned T_MAX_GREEN = 1500000000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] req,
  output logic [7:0] signal,
  output logic [1:0] grant,
  output logic [1:0] state,
  output logic [3:0] pending
);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10
  } phase_e;

  // Terminal counts: the timer runs 0..T-1 inside a phase.
  localparam logic [30:0] ALLRED_TC = 31'(T_ALLRED - 1);
  localparam logic [30:0] YELLOW_TC = 31'(T_YELLOW - 1);
  localparam logic [30:0] MIN_TC    = 31'(T_MIN_GREEN - 1);
  localparam logic [30:0] MAX_TC    = 31'(T_MAX_GREEN - 1);

  phase_e      phase_q;
  phase_e      phase_d;
  logic [30:0] count;
  logic [1:0]  next_grant;
  logic [3:0]  req_m;
  logic [3:0]  req_s;
  logic [3:0]  green_mask;
  logic [3:0]  grant_mask;
  logic        other;
  logic [1:0]  rr_pick;
  logic        rr_found;
  logic [1:0]  rr_idx;

  // Two-flop synchronizer on the raw approach sensors.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      req_m <= 4'b0000;
      req_s <= 4'b0000;
    end else begin
      req_m <= req;
      req_s <= req_m;
    end
  end

  // Competing demand and round-robin search starting after the current owner.
  always_comb begin
    grant_mask = 4'b0001 << grant;
    green_mask = (phase_q == ST_GREEN) ? grant_mask : 4'b0000;
    other      = |(pending & ~grant_mask);
    rr_pick    = grant;
    rr_found   = 1'b0;
    rr_idx     = grant;
    for (int k = 1; k < 4; k++) begin
      rr_idx = grant + 2'(k);
      if (!rr_found && pending[rr_idx]) begin
        rr_pick  = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  // Next-phase decision.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      ST_ALLRED: if (count == ALLRED_TC) phase_d = ST_GREEN;
      ST_GREEN:  if (other && ((count >= MIN_TC && !req_s[grant]) || count >= MAX_TC))
                   phase_d = ST_YELLOW;
      ST_YELLOW: if (count == YELLOW_TC) phase_d = ST_ALLRED;
      default:   phase_d = ST_ALLRED;
    endcase
  end

  // Phase register, timer, grant hand-off and pending latches.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      phase_q    <= ST_ALLRED;
      count      <= 31'd0;
      grant      <= 2'd0;
      next_grant <= 2'd0;
      pending    <= 4'b0000;
    end else begin
      phase_q <= phase_d;
      if (phase_d != phase_q)
        count <= 31'd0;
      else if (!(phase_q == ST_GREEN && count >= MAX_TC))
        count <= count + 31'd1;
      if (phase_q == ST_ALLRED && phase_d == ST_GREEN)
        grant <= next_grant;
      if (phase_q == ST_GREEN && phase_d == ST_YELLOW)
        next_grant <= rr_pick;
      // Clear wins over set for the approach that is currently green.
      pending <= (pending | req_s) & ~green_mask;
    end
  end

  // Lamp decode from registered phase/grant only.
  always_comb begin
    signal = 8'h55;
    case (phase_q)
      ST_GREEN:  signal[{grant, 1'b0} +: 2] = 2'b11;
      ST_YELLOW: signal[{grant, 1'b0} +: 2] = 2'b10;
      default:   signal = 8'h55;
    endcase
  end

  assign state = phase_q;

endmodule

// File: tb/tb_tlc_phase_arbiter.sv
// Scoreboard bench for tlc_phase_arbiter: stimulus pushes the expected
// sequence of phase changes, a monitor pops one entry per observed change.
module tb_tlc_phase_arbiter;

  logic       Clk;
  logic       Rst;
  logic [3:0] req;
  logic [7:0] signal;
  logic [1:0] grant;
  logic [1:0] state;
  logic [3:0] pending;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] gr;
    logic [7:0] sig;
    int         dur;   // 0 = duration not checked
  } exp_t;

  exp_t exp_q[$];

  localparam logic [1:0] AR = 2'b00, GR = 2'b01, YE = 2'b10;

  tlc_phase_arbiter #(
    .T_ALLRED(2), .T_YELLOW(3), .T_MIN_GREEN(5), .T_MAX_GREEN(10)
  ) dut (
    .Clk(Clk), .Rst(Rst), .req(req),
    .signal(signal), .grant(grant), .state(state), .pending(pending)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic void push(input logic [1:0] st, input logic [1:0] gr,
                               input logic [7:0] sig, input int dur);
    exp_t e;
    e.st = st; e.gr = gr; e.sig = sig; e.dur = dur;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  task automatic wait_drain(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge Clk); #2;
      if (exp_q.size() == 0) done = 1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout left=%0d want=0 at %0t", exp_q.size(), $time);
      exp_q.delete();
    end
  endtask

  task automatic wait_state(input logic [1:0] st, input logic [1:0] gr, input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge Clk); #2;
      if (state == st && grant == gr) done = 1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL state_timeout got st=%b gr=%0d want st=%b gr=%0d", state, grant, st, gr);
    end
  endtask

  task automatic pulse(input logic [3:0] v);
    req = v;
    @(negedge Clk); #2;
    req = 4'b0000;
  endtask

  // Monitor: every phase change pops and checks one expectation.
  initial begin : monitor
    logic [1:0] prev;
    int         dur;
    exp_t       e;
    prev = AR; dur = 0;
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        prev = AR; dur = 0;
      end else if (state != prev) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change got st=%b gr=%0d sig=%h want none", state, grant, signal);
        end else begin
          e = exp_q.pop_front();
          if (state !== e.st || grant !== e.gr || signal !== e.sig ||
              (e.dur != 0 && dur != e.dur)) begin
            n_bad++;
            $display("FAIL phase_change got st=%b gr=%0d sig=%h prev_dur=%0d want st=%b gr=%0d sig=%h prev_dur=%0d",
                     state, grant, signal, dur, e.st, e.gr, e.sig, e.dur);
          end
        end
        prev = state; dur = 1;
      end else begin
        dur++;
      end
    end
  end

  initial begin
    Rst = 1'b1; req = 4'b0000;
    #2 Rst = 1'b0;
    #1;
    chk("rst_signal", 32'(signal), 32'h55);
    chk("rst_state", 32'(state), 32'(AR));
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);

    // Scenario 1: home green after 2 all-red cycles, rest in green.
    push(GR, 2'd0, 8'h57, 2);
    #20; @(posedge Clk); #1 Rst = 1'b1;
    wait_drain(20);
    repeat (15) @(negedge Clk); #2;
    chk("rest_state", 32'(state), 32'(GR));
    chk("rest_grant", 32'(grant), 32'd0);
    chk("rest_signal", 32'(signal), 32'h57);
    chk("rest_count_sat", 32'(dut.count), 32'd9);
    chk("rest_pending", 32'(pending), 32'd0);

    // Scenario 2: req[2] pulse; req[0] pulse during yellow gives a 5-cycle green on 2.
    push(YE, 2'd0, 8'h56, 0);
    push(AR, 2'd0, 8'h55, 3);
    push(GR, 2'd2, 8'h75, 2);
    push(YE, 2'd2, 8'h65, 5);
    push(AR, 2'd2, 8'h55, 3);
    push(GR, 2'd0, 8'h57, 2);
    req = 4'b0100;
    @(negedge Clk); #2;
    req = 4'b0000;
    @(negedge Clk); #2;
    chk("pend2_after_2_edges", 32'(pending[2]), 32'd0);
    @(negedge Clk); #2;
    chk("pend2_after_3_edges", 32'(pending[2]), 32'd1);
    chk("still_green_on_0", 32'(state), 32'(GR));
    wait_state(YE, 2'd0, 10);
    pulse(4'b0001);
    wait_state(GR, 2'd2, 20);
    @(negedge Clk); #2;
    chk("pend2_cleared_in_green", 32'(pending[2]), 32'd0);
    wait_drain(60);
    repeat (3) @(negedge Clk); #2;
    chk("pending_idle", 32'(pending), 32'd0);

    // Scenario 3: req[0] and req[1] held, max-out greens of 10 cycles.
    push(YE, 2'd0, 8'h56, 0);
    push(AR, 2'd0, 8'h55, 3);
    push(GR, 2'd1, 8'h5D, 2);
    push(YE, 2'd1, 8'h59, 10);
    push(AR, 2'd1, 8'h55, 3);
    push(GR, 2'd0, 8'h57, 2);
    push(YE, 2'd0, 8'h56, 10);
    push(AR, 2'd0, 8'h55, 3);
    push(GR, 2'd1, 8'h5D, 2);
    req = 4'b0011;
    wait_drain(200);

    // Scenario 4: all requests held, grants rotate 1,2,3,0,1.
    push(YE, 2'd1, 8'h59, 10);
    push(AR, 2'd1, 8'h55, 3);
    push(GR, 2'd2, 8'h75, 2);
    push(YE, 2'd2, 8'h65, 10);
    push(AR, 2'd2, 8'h55, 3);
    push(GR, 2'd3, 8'hD5, 2);
    push(YE, 2'd3, 8'h95, 10);
    push(AR, 2'd3, 8'h55, 3);
    push(GR, 2'd0, 8'h57, 2);
    push(YE, 2'd0, 8'h56, 10);
    push(AR, 2'd0, 8'h55, 3);
    push(GR, 2'd1, 8'h5D, 2);
    req = 4'b1111;
    wait_drain(300);

    // Requests drop: latched pendings are served with demand-gap greens of 5.
    push(YE, 2'd1, 8'h59, 5);
    push(AR, 2'd1, 8'h55, 3);
    push(GR, 2'd2, 8'h75, 2);
    push(YE, 2'd2, 8'h65, 5);
    push(AR, 2'd2, 8'h55, 3);
    push(GR, 2'd3, 8'hD5, 2);
    push(YE, 2'd3, 8'h95, 5);
    push(AR, 2'd3, 8'h55, 3);
    push(GR, 2'd0, 8'h57, 2);
    req = 4'b0000;
    wait_drain(200);

    // Scenario 5: req[3] and req[1] pending from green 0 -> 1 then 3.
    repeat (3) @(negedge Clk); #2;
    push(YE, 2'd0, 8'h56, 0);
    push(AR, 2'd0, 8'h55, 3);
    push(GR, 2'd1, 8'h5D, 2);
    push(YE, 2'd1, 8'h59, 5);
    push(AR, 2'd1, 8'h55, 3);
    push(GR, 2'd3, 8'hD5, 2);
    pulse(4'b1010);
    wait_drain(200);

    // Scenario 6: reset asserted between edges during yellow.
    repeat (3) @(negedge Clk); #2;
    push(YE, 2'd3, 8'h95, 0);
    pulse(4'b0001);
    wait_drain(50);
    #1 Rst = 1'b0;
    #1;
    chk("midrst_signal", 32'(signal), 32'h55);
    chk("midrst_state", 32'(state), 32'(AR));
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_pending", 32'(pending), 32'd0);
    push(GR, 2'd0, 8'h57, 2);
    @(posedge Clk); @(posedge Clk); #1 Rst = 1'b1;
    wait_drain(20);
    repeat (15) @(negedge Clk); #2;
    chk("resume_state", 32'(state), 32'(GR));
    chk("resume_grant", 32'(grant), 32'd0);
    chk("resume_signal", 32'(signal), 32'h57);
    chk("resume_count_sat", 32'(dut.count), 32'd9);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
